ov7670_sccb_config: RTL and testbench

//  Configures the OV7670 over SCCB (3-phase write) before capture: on iniciar, replays a fixed
//  5-entry register table to the sensor, then flags pronto. Sits beside the capture

---
 rtl/ov7670_sccb_config.sv | 232 +++++++++++++++++++++++
 tb/tb_ov7670_sccb_config.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_config.sv
// OV7670 SCCB configuration master: on iniciar, writes a fixed 5-entry register table
// as 3-phase SCCB writes, waits after the soft-reset entry, then holds pronto.
module ov7670_sccb_config #(
   parameter int unsigned TICK_DIV     = 125,
   parameter int unsigned DELAY_CYCLES = 50000,
   parameter logic [7:0]  SLAVE_ID     = 8'h42
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   output logic       SDIOC,
   output logic       SDIOD,
   output logic       ocupado,
   output logic       pronto,
   output logic [2:0] db_indice,
   output logic [3:0] db_estado
);

   localparam logic [3:0] INICIAL = 4'd0;
   localparam logic [3:0] CARREGA = 4'd1;
   localparam logic [3:0] START   = 4'd2;
   localparam logic [3:0] BITS    = 4'd3;
   localparam logic [3:0] STOP    = 4'd4;
   localparam logic [3:0] GAP     = 4'd5;
   localparam logic [3:0] ESPERA  = 4'd6;
   localparam logic [3:0] PRONTO  = 4'd7;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);

   logic [3:0]    estado_q, estado_d;
   logic [2:0]    indice_q, indice_d;
   logic [1:0]    quarter_q, quarter_d;
   logic [4:0]    bit_q, bit_d;
   logic [26:0]   shift_q, shift_d;
   logic [DW-1:0] delay_q, delay_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          sioc_q, sioc_d;
   logic          siod_q, siod_d;
   logic          ocupado_q, ocupado_d;
   logic          pronto_q, pronto_d;
   logic          tick;
   logic [15:0]   entrada;

   // Register table, {addr, data}; entry 0 is the soft reset that needs the settle delay.
   function automatic logic [15:0] tabela(input logic [2:0] idx);
      case (idx)
         3'd0:    tabela = 16'h1280;
         3'd1:    tabela = 16'h1204;
         3'd2:    tabela = 16'h40D0;
         3'd3:    tabela = 16'h1101;
         3'd4:    tabela = 16'h0C00;
         default: tabela = 16'h0C00;
      endcase
   endfunction

   assign entrada = tabela(indice_q);

   // Quarter-bit tick generator; idles at zero whenever no sequence is running.
   always_comb begin
      tick_cnt_d = '0;
      if (ocupado_q && (tick_cnt_q != TICK_LAST)) begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end
   end

   assign tick = ocupado_q && (tick_cnt_q == TICK_LAST);

   always_comb begin
      estado_d  = estado_q;
      indice_d  = indice_q;
      quarter_d = quarter_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      delay_d   = delay_q;
      sioc_d    = sioc_q;
      siod_d    = siod_q;
      ocupado_d = ocupado_q;
      pronto_d  = pronto_q;

      case (estado_q)
         INICIAL, PRONTO: begin
            sioc_d = 1'b1;
            siod_d = 1'b1;
            if (iniciar) begin
               estado_d  = CARREGA;
               pronto_d  = 1'b0;
               ocupado_d = 1'b1;
               indice_d  = 3'd0;
            end
         end

         CARREGA: begin
            shift_d   = {SLAVE_ID, 1'b1, entrada[15:8], 1'b1, entrada[7:0], 1'b1};
            quarter_d = 2'd0;
            bit_d     = 5'd0;
            estado_d  = START;
         end

         START: begin
            if (tick) begin
               quarter_d = quarter_q + 2'd1;
               case (quarter_q)
                  2'd0: begin
                     sioc_d = 1'b1;
                     siod_d = 1'b1;
                  end
                  2'd1: siod_d = 1'b0;
                  2'd3: begin
                     sioc_d   = 1'b0;
                     estado_d = BITS;
                  end
                  default: ;
               endcase
            end
         end

         // Data is set up in q0 while SIOC is low, so SIOD never moves under a high clock.
         BITS: begin
            if (tick) begin
               quarter_d = quarter_q + 2'd1;
               case (quarter_q)
                  2'd0: siod_d = shift_q[26];
                  2'd1: sioc_d = 1'b1;
                  2'd3: begin
                     sioc_d  = 1'b0;
                     shift_d = {shift_q[25:0], 1'b1};
                     bit_d   = bit_q + 5'd1;
                     if (bit_q == 5'd26) begin
                        estado_d = STOP;
                     end
                  end
                  default: ;
               endcase
            end
         end

         STOP: begin
            if (tick) begin
               quarter_d = quarter_q + 2'd1;
               case (quarter_q)
                  2'd0: siod_d = 1'b0;
                  2'd1: sioc_d = 1'b1;
                  2'd3: begin
                     siod_d   = 1'b1;
                     estado_d = GAP;
                  end
                  default: ;
               endcase
            end
         end

         GAP: begin
            sioc_d = 1'b1;
            siod_d = 1'b1;
            if (tick) begin
               quarter_d = quarter_q + 2'd1;
               if (quarter_q == 2'd3) begin
                  if (indice_q == 3'd0) begin
                     delay_d  = '0;
                     estado_d = ESPERA;
                  end else if (indice_q == 3'd4) begin
                     pronto_d  = 1'b1;
                     ocupado_d = 1'b0;
                     estado_d  = PRONTO;
                  end else begin
                     indice_d = indice_q + 3'd1;
                     estado_d = CARREGA;
                  end
               end
            end
         end

         ESPERA: begin
            if (delay_q == DELAY_LAST) begin
               delay_d  = '0;
               indice_d = 3'd1;
               estado_d = CARREGA;
            end else begin
               delay_d = delay_q + 1'b1;
            end
         end

         default: begin
            estado_d  = INICIAL;
            sioc_d    = 1'b1;
            siod_d    = 1'b1;
            ocupado_d = 1'b0;
            pronto_d  = 1'b0;
            indice_d  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= INICIAL;
         indice_q   <= 3'd0;
         quarter_q  <= 2'd0;
         bit_q      <= 5'd0;
         shift_q    <= '0;
         delay_q    <= '0;
         tick_cnt_q <= '0;
         sioc_q     <= 1'b1;
         siod_q     <= 1'b1;
         ocupado_q  <= 1'b0;
         pronto_q   <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         indice_q   <= indice_d;
         quarter_q  <= quarter_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         delay_q    <= delay_d;
         tick_cnt_q <= tick_cnt_d;
         sioc_q     <= sioc_d;
         siod_q     <= siod_d;
         ocupado_q  <= ocupado_d;
         pronto_q   <= pronto_d;
      end
   end

   assign SDIOC     = sioc_q;
   assign SDIOD     = siod_q;
   assign ocupado   = ocupado_q;
   assign pronto    = pronto_q;
   assign db_indice = indice_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: decodes the SCCB bus and scores every write against
// hand-written table frames, plus directed checks on status outputs.
module tb_ov7670_sccb_config;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       SDIOC;
   logic       SDIOD;
   logic       ocupado;
   logic       pronto;
   logic [2:0] db_indice;
   logic [3:0] db_estado;

   ov7670_sccb_config #(
      .TICK_DIV    (2),
      .DELAY_CYCLES(100),
      .SLAVE_ID    (8'h42)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .iniciar  (iniciar),
      .SDIOC    (SDIOC),
      .SDIOD    (SDIOD),
      .ocupado  (ocupado),
      .pronto   (pronto),
      .db_indice(db_indice),
      .db_estado(db_estado)
   );

   // clock/reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   logic [26:0] exp_q[$];

   // Expected frames written out by hand: {ID, 1, addr, 1, data, 1}.
   logic [26:0] exp_frames[5];
   initial begin
      exp_frames[0] = {8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1};
      exp_frames[1] = {8'h42, 1'b1, 8'h12, 1'b1, 8'h04, 1'b1};
      exp_frames[2] = {8'h42, 1'b1, 8'h40, 1'b1, 8'hD0, 1'b1};
      exp_frames[3] = {8'h42, 1'b1, 8'h11, 1'b1, 8'h01, 1'b1};
      exp_frames[4] = {8'h42, 1'b1, 8'h0C, 1'b1, 8'h00, 1'b1};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bus monitor / scoreboard
   int          cyc = 0;
   int          rx_cnt = 0;
   int          start_cnt = 0;
   int          stop_cyc = 0;
   int          gap_e01 = -1;
   int          idle_viol = 0;
   int          bits = 0;
   logic        in_frame = 1'b0;
   logic        prev_c = 1'b1;
   logic        prev_d = 1'b1;
   logic [27:0] frame = '0;

   initial forever begin
      logic c, d;
      @(negedge clock);
      cyc++;
      if (reset) begin
         in_frame = 1'b0;
         bits     = 0;
         prev_c   = 1'b1;
         prev_d   = 1'b1;
      end else begin
         c = SDIOC;
         d = SDIOD;
         if (prev_c && c && prev_d && !d) begin
            in_frame = 1'b1;
            bits     = 0;
            frame    = '0;
            start_cnt++;
            if (rx_cnt == 1 && gap_e01 < 0) gap_e01 = cyc - stop_cyc;
         end else if (prev_c && c && !prev_d && d && in_frame) begin
            // the STOP rising SIOC is seen as a 28th bit (SIOD low) and dropped
            in_frame = 1'b0;
            stop_cyc = cyc;
            rx_cnt++;
            check($sformatf("rx%0d_bits", rx_cnt), bits, 28);
            if (exp_q.size() == 0) begin
               check($sformatf("rx%0d_unexpected", rx_cnt), exp_q.size(), 1);
            end else begin
               check($sformatf("rx%0d_frame", rx_cnt), frame[27:1], exp_q.pop_front());
            end
         end else if (!prev_c && c && in_frame) begin
            frame = {frame[26:0], d};
            bits++;
         end else if (!in_frame && !(c && d)) begin
            idle_viol++;
         end
         prev_c = c;
         prev_d = d;
      end
   end

   // driver tasks
   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic pulse_iniciar();
      step();
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
   endtask

   task automatic push_run(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(exp_frames[i]);
   endtask

   task automatic wait_rx(input int target, input string tag);
      for (int n = 0; n < 4000 && rx_cnt < target; n++) step();
      check(tag, rx_cnt >= target, 1);
   endtask

   task automatic wait_pronto(input string tag);
      for (int n = 0; n < 4000 && !pronto; n++) step();
      check(tag, pronto, 1);
   endtask

   task automatic wait_bits_of(input logic [2:0] idx, input string tag);
      for (int n = 0; n < 4000 && !(db_indice == idx && db_estado == 4'd3); n++) step();
      check(tag, {db_indice, db_estado}, {idx, 4'd3});
   endtask

   initial begin
      reset   = 1'b1;
      iniciar = 1'b0;
      repeat (3) step();

      // reset state, checked while reset is held
      check("rst_sioc", SDIOC, 1);
      check("rst_siod", SDIOD, 1);
      check("rst_ocupado", ocupado, 0);
      check("rst_pronto", pronto, 0);
      check("rst_indice", db_indice, 0);
      check("rst_estado", db_estado, 0);
      reset = 1'b0;
      repeat (3) step();
      check("idle_estado", db_estado, 0);

      // run 1: full sequence
      push_run(5);
      pulse_iniciar();
      check("start_ocupado", ocupado, 1);
      check("start_estado_carrega", db_estado, 1);
      wait_rx(1, "wait_e0");
      check("e0_one_start_seen", start_cnt, 1);
      wait_rx(5, "wait_run1");
      wait_pronto("wait_pronto1");
      check("gap_e0_e1_ge108", gap_e01 >= 108, 1);
      check("run1_pronto", pronto, 1);
      check("run1_ocupado", ocupado, 0);
      check("run1_estado", db_estado, 7);
      check("run1_indice", db_indice, 4);
      check("run1_sioc", SDIOC, 1);
      check("run1_siod", SDIOD, 1);
      check("run1_exp_left", exp_q.size(), 0);
      repeat (10) step();
      check("pronto_held", pronto, 1);

      // run 2: restart from PRONTO, iniciar during entry 2 must be ignored
      push_run(5);
      pulse_iniciar();
      check("restart_pronto_clr", pronto, 0);
      check("restart_indice", db_indice, 0);
      check("restart_ocupado", ocupado, 1);
      wait_bits_of(3'd2, "wait_e2_bits");
      pulse_iniciar();
      check("busy_iniciar_indice", db_indice, 2);
      check("busy_iniciar_estado", db_estado, 3);
      wait_pronto("wait_pronto2");
      check("run2_rx_cnt", rx_cnt, 10);
      check("run2_exp_left", exp_q.size(), 0);

      // run 3: reset in the middle of entry 3
      push_run(3);
      pulse_iniciar();
      wait_bits_of(3'd3, "wait_e3_bits");
      repeat (20) step();
      check("mid_e3_estado", db_estado, 3);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_sioc", SDIOC, 1);
      check("midrst_siod", SDIOD, 1);
      check("midrst_pronto", pronto, 0);
      check("midrst_indice", db_indice, 0);
      check("midrst_ocupado", ocupado, 0);
      check("midrst_estado", db_estado, 0);
      repeat (3) step();
      reset = 1'b0;
      check("run3_rx_cnt", rx_cnt, 13);
      check("run3_exp_left", exp_q.size(), 0);

      // run 4: after the reset, next iniciar starts again at entry 0
      push_run(1);
      step();
      pulse_iniciar();
      check("run4_indice", db_indice, 0);
      wait_rx(14, "wait_run4_e0");
      check("run4_exp_left", exp_q.size(), 0);
      check("bus_idle_high", idle_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
